// File: rtl/da1_dac_rx.sv
// DA1 DAC link receiver: synchronizes the serial sync/sck/data pins into dacclk,
// collects 16-bit frames and hands off command/data bytes with valid/overrun/error flags.
module da1_dac_rx #(
  parameter int unsigned SYNCSTAGES = 2
) (
  input  logic       dacclk,
  input  logic       dacrst,
  input  logic       dacsync,
  input  logic       dacsck,
  input  logic       dacout,
  input  logic       rxack,
  output logic [7:0] rxcmd,
  output logic [7:0] rxdata,
  output logic       rxdav,
  output logic       rxerr,
  output logic       rxovr
);

  typedef enum logic [1:0] {StSyncWait, StIdle, StShift} state_e;

  state_e                state_q, state_d;
  logic [SYNCSTAGES-1:0] sync_q, sck_q, dout_q;
  logic                  sync_dly_q, sck_dly_q;
  logic [15:0]           shreg_q, shreg_d;
  logic [4:0]            cnt_q, cnt_d;
  logic [7:0]            cmd_q, cmd_d, data_q, data_d;
  logic                  dav_q, dav_d, err_q, err_d, ovr_q, ovr_d;
  logic                  sync_s, sck_s, dout_s;
  logic                  sync_rise, sync_fall, sck_rise, complete;

  // Data runs through the same number of stages as sck so a detected sck edge
  // lines up with the bit that was on the pin alongside it.
  assign sync_s    = sync_q[SYNCSTAGES-1];
  assign sck_s     = sck_q[SYNCSTAGES-1];
  assign dout_s    = dout_q[SYNCSTAGES-1];
  assign sync_rise = sync_s & ~sync_dly_q;
  assign sync_fall = ~sync_s & sync_dly_q;
  assign sck_rise  = sck_s & ~sck_dly_q;

  always_ff @(posedge dacclk) begin
    if (dacrst) begin
      state_q    <= StSyncWait;
      sync_q     <= '0;
      sck_q      <= '0;
      dout_q     <= '0;
      sync_dly_q <= 1'b0;
      sck_dly_q  <= 1'b0;
      shreg_q    <= '0;
      cnt_q      <= '0;
      cmd_q      <= '0;
      data_q     <= '0;
      dav_q      <= 1'b0;
      err_q      <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      sync_q     <= {sync_q[SYNCSTAGES-2:0], dacsync};
      sck_q      <= {sck_q[SYNCSTAGES-2:0], dacsck};
      dout_q     <= {dout_q[SYNCSTAGES-2:0], dacout};
      sync_dly_q <= sync_s;
      sck_dly_q  <= sck_s;
      shreg_q    <= shreg_d;
      cnt_q      <= cnt_d;
      cmd_q      <= cmd_d;
      data_q     <= data_d;
      dav_q      <= dav_d;
      err_q      <= err_d;
      ovr_q      <= ovr_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    cnt_d    = cnt_q;
    err_d    = 1'b0;
    complete = 1'b0;
    unique case (state_q)
      StSyncWait: begin
        if (sync_s) state_d = StIdle;
      end
      StIdle: begin
        if (sync_fall) begin
          state_d = StShift;
          shreg_d = '0;
          cnt_d   = '0;
        end
      end
      StShift: begin
        // A sync rise wins over a coincident sck rise.
        if (sync_rise) begin
          state_d = StIdle;
          if (cnt_q == 5'd16) complete = 1'b1;
          else                err_d    = 1'b1;
        end else if (sck_rise) begin
          shreg_d = {shreg_q[14:0], dout_s};
          if (cnt_q != 5'd17) cnt_d = cnt_q + 5'd1;
        end
      end
      default: state_d = StSyncWait;
    endcase

    cmd_d  = cmd_q;
    data_d = data_q;
    dav_d  = dav_q;
    ovr_d  = ovr_q;
    if (complete) begin
      if (!dav_q || rxack) begin
        cmd_d  = shreg_q[15:8];
        data_d = shreg_q[7:0];
        dav_d  = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (rxack) begin
      dav_d = 1'b0;
      ovr_d = 1'b0;
    end
  end

  assign rxcmd  = cmd_q;
  assign rxdata = data_q;
  assign rxdav  = dav_q;
  assign rxerr  = err_q;
  assign rxovr  = ovr_q;

endmodule
